// File: rtl/fifo_wr_arb_if.sv
// Bundle of requester, grant and FIFO write-port signals shared by the
// arbiter and its environment.
interface fifo_wr_arb_if;
   logic [3:0]   i_req;
   logic [7:0]   i_len;
   logic [383:0] i_data;
   logic [3:0]   o_ack;
   logic [3:0]   o_grant;
   logic [95:0]  o_fifo_wr_data;
   logic         o_fifo_wr_en;
   logic         i_fifo_full;
   logic [9:0]   i_fifo_wr_words;
   logic         o_busy;

   // Arbiter side: consumes requests and FIFO status, drives the write port.
   modport master (
      input  i_req, i_len, i_data, i_fifo_full, i_fifo_wr_words,
      output o_ack, o_grant, o_fifo_wr_data, o_fifo_wr_en, o_busy
   );

   // Environment side: requesters plus the FIFO.
   modport slave (
      output i_req, i_len, i_data, i_fifo_full, i_fifo_wr_words,
      input  o_ack, o_grant, o_fifo_wr_data, o_fifo_wr_en, o_busy
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Four-way round-robin packet arbiter for a single FIFO write port.
// A requester is granted only if its whole packet fits in the FIFO, and the
// packet is then written word by word without interleaving.
module fifo_wr_arb #(
   parameter int FIFO_WORDS = 512
) (
   input  logic          clk,
   input  logic          rst_n,
   fifo_wr_arb_if.master bus
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  cnt_q;
   logic [1:0]  len_q;
   logic [1:0]  gnt_idx_q;
   logic [1:0]  last_q;
   logic [3:0]  grant_q;

   logic [10:0] cap;
   logic [10:0] words_ext;
   logic [10:0] free_space;
   logic [3:0]  elig;
   logic        found;
   logic [1:0]  sel;
   logic [1:0]  idx;
   logic        wr;
   logic        done;
   logic [3:0]  ack;
   logic [95:0] wr_data;

   assign cap       = 11'(FIFO_WORDS);
   assign words_ext = {1'b0, bus.i_fifo_wr_words};
   // An occupancy above capacity is treated as no room rather than wrapping.
   assign free_space = (words_ext > cap) ? 11'd0 : (cap - words_ext);

   // Eligibility: request present and the full packet fits in free space.
   always_comb begin
      elig = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         elig[k] = bus.i_req[k] &&
                   (free_space >= (11'(bus.i_len[2*k +: 2]) + 11'd1));
      end
   end

   // Round-robin search starting just after the last-served requester.
   always_comb begin
      found = 1'b0;
      sel   = last_q;
      idx   = last_q;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!found && elig[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Final word of the packet being accepted this cycle.
   assign done = wr && (cnt_q == len_q);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (found) state_d = XFER;
         XFER: if (done)  state_d = IDLE;
         default:         state_d = IDLE;
      endcase
   end

   // Output logic: write port and ack are live only while transferring.
   always_comb begin
      wr      = 1'b0;
      ack     = 4'b0000;
      wr_data = '0;
      if (state_q == XFER) begin
         wr_data        = bus.i_data[int'(gnt_idx_q)*96 +: 96];
         wr             = bus.i_req[gnt_idx_q] && !bus.i_fifo_full;
         ack[gnt_idx_q] = wr;
      end
   end

   // Packet bookkeeping: grant, latched length, word counter, last-served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= 2'd0;
         len_q     <= 2'd0;
         gnt_idx_q <= 2'd0;
         last_q    <= 2'd3;
         grant_q   <= 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  gnt_idx_q <= sel;
                  len_q     <= bus.i_len[2*sel +: 2];
                  cnt_q     <= 2'd0;
                  grant_q   <= 4'b0001 << sel;
               end
            end
            XFER: begin
               if (done) begin
                  last_q  <= gnt_idx_q;
                  grant_q <= 4'b0000;
                  cnt_q   <= 2'd0;
               end else if (wr) begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            default: grant_q <= 4'b0000;
         endcase
      end
   end

   assign bus.o_fifo_wr_en   = wr;
   assign bus.o_ack          = ack;
   assign bus.o_fifo_wr_data = wr_data;
   assign bus.o_grant        = grant_q;
   assign bus.o_busy         = (state_q == XFER);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: requester models feed packets, the
// expected write stream is queued up front and checked word by word.
module tb_fifo_wr_arb;

   logic clk;
   logic rst_n;

   fifo_wr_arb_if bus();

   fifo_wr_arb #(.FIFO_WORDS(512)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [95:0] data;
      logic [3:0]  owner;
   } exp_t;

   exp_t sbq[$];

   int tests_run;
   int tests_failed;

   logic [3:0] reqv;
   int widx[4];
   int pkt[4];
   int npk[4];
   int lenf[4];
   int len_drv[4];

   logic        s_wr;
   logic        s_busy;
   logic [3:0]  s_ack;
   logic [3:0]  s_grant;
   logic [95:0] s_data;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] mkword(input int k, input int p, input int w);
      return {8'(k), 8'(p), 8'(w), 24'hC3C3C3, 48'h0123_4567_89AB};
   endfunction

   task automatic push_pkt(input int k, input int p, input int nwords);
      exp_t e;
      for (int w = 0; w < nwords; w++) begin
         e.data  = mkword(k, p, w);
         e.owner = 4'b0001 << k;
         sbq.push_back(e);
      end
   endtask

   task automatic drive();
      bus.i_req = reqv;
      for (int k = 0; k < 4; k++) begin
         bus.i_len[2*k +: 2]   = 2'(len_drv[k]);
         bus.i_data[96*k +: 96] = mkword(k, pkt[k], widx[k]);
      end
   endtask

   task automatic start_req(input int k, input int len, input int n);
      lenf[k]    = len;
      len_drv[k] = len;
      npk[k]     = n;
      widx[k]    = 0;
      pkt[k]     = 0;
      reqv[k]    = 1'b1;
      drive();
   endtask

   // One clock: sample and score at negedge, then advance requester models.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      s_wr    = bus.o_fifo_wr_en;
      s_busy  = bus.o_busy;
      s_ack   = bus.o_ack;
      s_grant = bus.o_grant;
      s_data  = bus.o_fifo_wr_data;
      if (s_wr) begin
         if (sbq.size() == 0) begin
            chk("unexpected_wr", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("wr_data", s_data, e.data);
            chk("wr_ack", s_ack, e.owner);
            chk("wr_grant", s_grant, e.owner);
         end
      end else begin
         chk("ack_no_wr", s_ack, 0);
      end
      if (!s_busy) chk("idle_data", s_data, 0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (s_ack[k]) begin
            if (widx[k] == lenf[k]) begin
               widx[k] = 0;
               pkt[k]++;
               npk[k]--;
               if (npk[k] <= 0) reqv[k] = 1'b0;
            end else begin
               widx[k]++;
            end
         end
      end
      drive();
   endtask

   task automatic wait_q(input string tag, input int left, input int budget, output int cycles);
      cycles = 0;
      while (sbq.size() > left && cycles < budget) begin
         tick();
         cycles++;
      end
      chk({tag, "_qleft"}, sbq.size(), left);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      reqv  = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         widx[k] = 0; pkt[k] = 0; npk[k] = 0; lenf[k] = 0; len_drv[k] = 0;
      end
      bus.i_fifo_full     = 1'b0;
      bus.i_fifo_wr_words = 10'd0;
      sbq.delete();
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_grant", bus.o_grant, 0);
      chk("rst_wr_en", bus.o_fifo_wr_en, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int cyc;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      bus.i_req           = 4'b0000;
      bus.i_len           = 8'd0;
      bus.i_data          = '0;
      bus.i_fifo_full     = 1'b0;
      bus.i_fifo_wr_words = 10'd0;

      // Single requester, 4 words; i_len changed mid-packet must not matter.
      do_reset();
      push_pkt(0, 0, 4);
      start_req(0, 3, 1);
      wait_q("single_a", 3, 20, cyc);
      len_drv[0] = 0;
      drive();
      wait_q("single_b", 0, 20, cyc);
      chk("single_tail_cycles", cyc, 3);
      tick();
      chk("single_idle_busy", s_busy, 0);
      chk("single_idle_grant", s_grant, 0);

      // Round-robin fairness with four 1-word requesters, two packets each.
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 4; k++) push_pkt(k, p, 1);
      for (int k = 0; k < 4; k++) start_req(k, 0, 2);
      wait_q("rr", 0, 60, cyc);
      chk("rr_cycles", cyc, 16);

      // Space check: 2 words free, req0 needs 4, req1 needs 2.
      do_reset();
      bus.i_fifo_wr_words = 10'd510;
      push_pkt(1, 0, 2);
      push_pkt(0, 0, 4);
      start_req(0, 3, 1);
      start_req(1, 1, 1);
      wait_q("space_a", 4, 30, cyc);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("space_hold_busy", s_busy, 0);
      end
      chk("space_hold_q", sbq.size(), 4);
      bus.i_fifo_wr_words = 10'd0;
      wait_q("space_b", 0, 30, cyc);

      // Backpressure: FIFO full for 3 cycles mid-packet.
      do_reset();
      push_pkt(0, 0, 4);
      start_req(0, 3, 1);
      wait_q("bp_a", 2, 20, cyc);
      bus.i_fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_wr", s_wr, 0);
         chk("bp_ack", s_ack, 0);
         chk("bp_busy", s_busy, 1);
      end
      bus.i_fifo_full = 1'b0;
      wait_q("bp_b", 0, 20, cyc);
      chk("bp_tail_cycles", cyc, 2);
      tick();
      chk("bp_done_busy", s_busy, 0);

      // Requester stall: req2 drops for 2 cycles mid-packet.
      do_reset();
      push_pkt(2, 0, 3);
      start_req(2, 2, 1);
      wait_q("stall_a", 2, 20, cyc);
      reqv[2] = 1'b0;
      drive();
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall_wr", s_wr, 0);
         chk("stall_busy", s_busy, 1);
         chk("stall_grant", s_grant, 4'b0100);
      end
      reqv[2] = 1'b1;
      drive();
      wait_q("stall_b", 0, 20, cyc);
      chk("stall_tail_cycles", cyc, 2);
      tick();
      chk("stall_done_busy", s_busy, 0);

      // Reset mid-packet after word 2 of 4; req0 wins again afterwards.
      do_reset();
      push_pkt(0, 0, 2);
      start_req(0, 3, 1);
      start_req(1, 3, 1);
      wait_q("rstm_a", 0, 20, cyc);
      rst_n = 1'b0;
      #1;
      chk("rstm_wr_en", bus.o_fifo_wr_en, 0);
      chk("rstm_ack", bus.o_ack, 0);
      chk("rstm_grant", bus.o_grant, 0);
      chk("rstm_busy", bus.o_busy, 0);
      chk("rstm_data", bus.o_fifo_wr_data, 0);
      widx[0] = 0;
      drive();
      push_pkt(0, 0, 4);
      push_pkt(1, 0, 4);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      wait_q("rstm_b", 0, 40, cyc);
      tick();
      chk("rstm_done_busy", s_busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Absolute guard so the run can never hang.
   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter FIFO_WORDS, default 512: capacity of the attached FIFO in words; used only for the free-space computation.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  4  per-requester packet request; held high by the requester until its last word is acked.
REQ-005 i_len  input  8  per-requester packet length minus one; requester k uses bits [2k+1:2k], so lengths are 1..4 words.
REQ-006 i_data  input  384  per-requester current word; requester k uses bits [96k+95:96k].
REQ-007 o_ack  output  4  one-hot per-word accept strobe to the granted requester.
REQ-008 o_grant  output  4  one-hot current owner of the FIFO write port; all zero when idle.
REQ-009 o_fifo_wr_data  output  96  word to the FIFO write port.
REQ-010 o_fifo_wr_en  output  1  FIFO write strobe.
REQ-011 i_fifo_full  input  1  FIFO full flag, write-clock domain.
REQ-012 i_fifo_wr_words  input  10  FIFO occupancy, write-clock domain, 0..FIFO_WORDS.
REQ-013 o_busy  output  1  high while in state XFER.

Function
REQ-014 States SHALL be IDLE and XFER; a 2-bit word counter, a 2-bit latched length, a 2-bit grant index and a 2-bit last-served index SHALL be registered.
REQ-015 Free space SHALL be computed as FIFO_WORDS minus i_fifo_wr_words at 11-bit width, with no underflow.
REQ-016 Requester k SHALL be eligible in IDLE when i_req[k]=1 and free space >= its length (i_len field + 1).
REQ-017 In IDLE with at least one eligible requester, the block SHALL select the first eligible requester, searching round-robin from last-served+1 modulo 4.
REQ-018 On that selection the block SHALL latch the grant index and length, clear the word counter, and enter XFER on the next edge; o_grant SHALL be registered and become valid in the same cycle as XFER.
REQ-019 A non-eligible requester SHALL be skipped without losing its round-robin position.
REQ-020 In XFER, o_fifo_wr_data SHALL be i_data of the granted requester (combinational mux).
REQ-021 In XFER, o_fifo_wr_en and o_ack[grant] SHALL equal i_req[grant] AND NOT i_fifo_full, combinationally in the same cycle.
REQ-022 In XFER, each cycle with o_fifo_wr_en=1 SHALL increment the word counter.
REQ-023 A write while the counter equals the latched length SHALL return the FSM to IDLE on the next edge, set last-served to the grant index and clear o_grant.
REQ-024 If i_fifo_full=1 or i_req[grant]=0 in XFER, the block SHALL stall with no write, no ack, and no counter or state change.
REQ-025 Changes to i_len or to other requests during XFER SHALL be ignored.
REQ-026 At least one IDLE cycle SHALL separate consecutive packets, so that i_fifo_wr_words reflects the prior packet before the next free-space check.
REQ-027 Every packet SHALL be written contiguously, with no interleaving between requesters.
REQ-028 Outside XFER, o_fifo_wr_data SHALL be zero and o_ack and o_fifo_wr_en SHALL be zero.

Reset
REQ-029 While rst_n=0, the block SHALL be in state IDLE, with o_grant=0, o_busy=0, word counter=0, latched length=0 and last-served=3 (requester 0 has first priority).
REQ-030 The combinational outputs SHALL be zero during reset.
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately, with no further writes; the requester re-requests after reset.
REQ-032 Release of reset SHALL be synchronous to clk; the first arbitration SHALL occur on the first edge after release.

Verification
REQ-033 Single requester: i_req=0001, len field=3, FIFO empty, no full -> o_grant=0001 for 4 cycles, 4 consecutive o_fifo_wr_en pulses carrying the requester's data, then 1 IDLE cycle.
REQ-034 Round-robin fairness: all 4 requesting 1-word packets continuously -> grant order 0,1,2,3,0,... with each grant separated by one IDLE cycle.
REQ-035 Space check: i_fifo_wr_words=510, req0 len 4, req1 len 2 -> req0 skipped, req1 granted; req0 granted first once free space >= 4.
REQ-036 Backpressure: i_fifo_full asserted for 3 cycles mid-packet -> no writes or acks during those cycles, remaining words written after deassertion, word count exact.
REQ-037 Requester stall: i_req[grant] drops for 2 cycles mid-packet -> FSM holds XFER with no writes, resumes, and the packet completes with the correct word count.
REQ-038 Reset mid-packet: rst_n low after word 2 of 4 -> outputs zero immediately; after release, requester 0 has priority.
